// File: rtl/hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared pipeline definitions for the hazard controller:
//   - hz_state_t  : MDU hold FSM states
//   - sb_entry_t  : one in-flight writer tracked by the scoreboard
//   - REG_W / REG_ZERO : register index width and the hard-wired zero register
//   - sb_match()  : RAW dependency test of one entry against the ID sources
// ----------------------------------------------------------------------------
package hazard_unit_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   // Wide enough for MDU_LATENCY-2 with MDU_LATENCY up to 16.
   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MDU_BUSY = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic             valid;
      logic             rw;
      logic [REG_W-1:0] rd;
      logic             mem_read;
   } sb_entry_t;

   // An entry blocks ID when it writes a non-zero register that ID really reads.
   function automatic logic sb_match(
      input sb_entry_t        e,
      input logic             id_valid,
      input logic [REG_W-1:0] rs,
      input logic             uses_rs,
      input logic [REG_W-1:0] rt,
      input logic             uses_rt
   );
      return e.valid & e.rw & (e.rd != REG_ZERO) & id_valid &
             ((uses_rs & (e.rd == rs)) | (uses_rt & (e.rd == rt)));
   endfunction

endpackage

// File: rtl/hazard_unit_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Three-deep shift register of in-flight writers (EX, MEM, WB) and the RAW
// match logic against the instruction currently in ID.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load              capture i_id_entry into EX (else EX gets a bubble)
//   i_id_entry          destination fields of the ID instruction
//   i_id_valid, i_id_rs, i_id_uses_rs, i_id_rt, i_id_uses_rt  ID sources
//   o_hit_ex            ID depends on the EX writer
//   o_hit_ex_load       ID depends on the EX writer and it is a load
//   o_hit_mem           ID depends on the MEM writer
// ----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_unit_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  sb_entry_t        i_id_entry,
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic             i_id_uses_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rt,
   output logic             o_hit_ex,
   output logic             o_hit_ex_load,
   output logic             o_hit_mem
);

   sb_entry_t r_sb_ex;
   sb_entry_t r_sb_mem;
   sb_entry_t r_sb_wb;
   logic      w_unused_bits;

   // Advance the writer pipeline one stage per cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb_ex  <= '0;
         r_sb_mem <= '0;
         r_sb_wb  <= '0;
      end else begin
         r_sb_wb  <= r_sb_mem;
         r_sb_mem <= r_sb_ex;
         r_sb_ex  <= i_load ? i_id_entry : '0;
      end
   end

   // RAW match against EX and MEM; WB never blocks since the register file
   // writes in the first half-cycle and reads in the second.
   always_comb begin
      o_hit_ex      = sb_match(r_sb_ex, i_id_valid, i_id_rs, i_id_uses_rs,
                               i_id_rt, i_id_uses_rt);
      o_hit_ex_load = o_hit_ex & r_sb_ex.mem_read;
      o_hit_mem     = sb_match(r_sb_mem, i_id_valid, i_id_rs, i_id_uses_rs,
                               i_id_rt, i_id_uses_rt);
   end

   // The WB entry and MEM load flag are tracked but never feed a decision.
   assign w_unused_bits = ^{r_sb_wb, r_sb_mem.mem_read};

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the 5-stage MIPS core. Decides when ID must
// stall (RAW hazards forwarding cannot cover, multi-cycle MDU ops) and
// squashes wrong-path instructions on a taken branch.
// Build option: define HAZARD_FWD_EN when the forwarding unit is present;
// only load-use hazards stall then. Undefined: any RAW against EX/MEM stalls.
// Parameter: MDU_LATENCY (2..16) total cycles an MDU op occupies ID.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_valid                   ID holds a real instruction
//   i_id_rs/rt, i_id_uses_rs/rt  ID source registers and their use flags
//   i_id_rd, i_id_rw             ID destination and register-write flag
//   i_id_mem_read, i_id_mdu      ID is a load / an MDU op
//   i_ex_branch_taken            branch resolved taken in EX
//   o_pc_write, o_if_id_write    PC and IF/ID load enables
//   o_id_ex_bubble               ID/EX loads a NOP
//   o_if_id_flush, o_id_ex_flush squash IF/ID and ID/EX
//   o_mdu_busy                   FSM is in MDU_BUSY
// ----------------------------------------------------------------------------
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MDU_LATENCY = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rs,
   input  logic             i_id_uses_rt,
   input  logic [REG_W-1:0] i_id_rd,
   input  logic             i_id_rw,
   input  logic             i_id_mem_read,
   input  logic             i_id_mdu,
   input  logic             i_ex_branch_taken,
   output logic             o_pc_write,
   output logic             o_if_id_write,
   output logic             o_id_ex_bubble,
   output logic             o_if_id_flush,
   output logic             o_id_ex_flush,
   output logic             o_mdu_busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

   hz_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;

   logic      w_hit_ex;
   logic      w_hit_ex_load;
   logic      w_hit_mem;
   logic      w_flush;
   logic      w_data_stall;
   logic      w_mdu_start;
   logic      w_mdu_hold;
   logic      w_stall;
   logic      w_sb_load;
   sb_entry_t w_id_entry;

   assign w_id_entry = '{valid: 1'b1, rw: i_id_rw, rd: i_id_rd,
                         mem_read: i_id_mem_read};

   hazard_scoreboard u_scoreboard (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_load        (w_sb_load),
      .i_id_entry    (w_id_entry),
      .i_id_valid    (i_id_valid),
      .i_id_rs       (i_id_rs),
      .i_id_uses_rs  (i_id_uses_rs),
      .i_id_rt       (i_id_rt),
      .i_id_uses_rt  (i_id_uses_rt),
      .o_hit_ex      (w_hit_ex),
      .o_hit_ex_load (w_hit_ex_load),
      .o_hit_mem     (w_hit_mem)
   );

`ifdef HAZARD_FWD_EN
   // Forwarding covers everything except a load result still in EX.
   logic w_unused_hits;
   assign w_unused_hits = w_hit_ex ^ w_hit_mem;
   assign w_data_stall  = w_hit_ex_load;
`else
   // No forwarding: wait until the producer has reached WB.
   logic w_unused_hits;
   assign w_unused_hits = w_hit_ex_load;
   assign w_data_stall  = w_hit_ex | w_hit_mem;
`endif

   // Stall/flush resolution; reset forces the quiescent output values.
   always_comb begin
      w_flush     = i_ex_branch_taken & ~i_rst;
      // A pending MDU op only starts counting once the data hazard is gone.
      w_mdu_start = (r_state == ST_IDLE) & i_id_valid & i_id_mdu & ~w_data_stall;
      w_mdu_hold  = (r_state == ST_MDU_BUSY) & (r_cnt != {CNT_W{1'b0}});
      w_stall     = ~i_rst & ~w_flush & (w_data_stall | w_mdu_start | w_mdu_hold);
      w_sb_load   = i_id_valid & ~w_stall & ~w_flush;
   end

   // MDU hold FSM: the start cycle plus MDU_LATENCY-2 counted cycles stall.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
      end else if (i_ex_branch_taken) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mdu_start) begin
                  r_state <= ST_MDU_BUSY;
                  r_cnt   <= CNT_INIT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_MDU_BUSY: begin
               if (r_cnt != {CNT_W{1'b0}}) begin
                  r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Control outputs; a flush never asserts a bubble because ID is killed.
   always_comb begin
      o_pc_write     = ~w_stall;
      o_if_id_write  = ~w_stall;
      o_id_ex_bubble = w_stall;
      o_if_id_flush  = w_flush;
      o_id_ex_flush  = w_flush;
      o_mdu_busy     = ~i_rst & (r_state == ST_MDU_BUSY);
   end

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
// Randomized stimulus against a behavioural model of the hazard rules: the
// model tracks in-flight writers as a 3-slot array and the MDU op by the
// number of cycles it has already spent in ID.
// ----------------------------------------------------------------------------
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   localparam int LAT    = 4;
   localparam int CYCLES = 3000;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid, id_uses_rs, id_uses_rt, id_rw, id_mem_read, id_mdu;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic             ex_branch_taken;
   logic             pc_write, if_id_write, id_ex_bubble;
   logic             if_id_flush, id_ex_flush, mdu_busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   hazard_unit #(.MDU_LATENCY(LAT)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_id_valid        (id_valid),
      .i_id_rs           (id_rs),
      .i_id_rt           (id_rt),
      .i_id_uses_rs      (id_uses_rs),
      .i_id_uses_rt      (id_uses_rt),
      .i_id_rd           (id_rd),
      .i_id_rw           (id_rw),
      .i_id_mem_read     (id_mem_read),
      .i_id_mdu          (id_mdu),
      .i_ex_branch_taken (ex_branch_taken),
      .o_pc_write        (pc_write),
      .o_if_id_write     (if_id_write),
      .o_id_ex_bubble    (id_ex_bubble),
      .o_if_id_flush     (if_id_flush),
      .o_id_ex_flush     (id_ex_flush),
      .o_mdu_busy        (mdu_busy)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   // Reference model state: writers in EX/MEM/WB, and MDU cycles used so far.
   typedef struct {
      bit v;
      bit rw;
      int rd;
      bit ld;
   } wr_t;
   wr_t m_pipe [3];
   int  m_age;

   function automatic int pick_reg();
      int r;
      case ($urandom_range(0, 4))
         0:       r = 0;
         1:       r = 4;
         2:       r = 8;
         default: r = 9;
      endcase
      return r;
   endfunction

   function automatic bit depends(wr_t w);
      return w.v && w.rw && (w.rd != 0) && id_valid &&
             ((id_uses_rs && (w.rd == int'(id_rs))) ||
              (id_uses_rt && (w.rd == int'(id_rt))));
   endfunction

   initial begin
      bit ds, stall, flush, busy, hold, did_mid_reset;
      int rst_left;
      for (int i = 0; i < 3; i++) m_pipe[i] = '{0, 0, 0, 0};
      m_age = 0;
      hold = 0;
      did_mid_reset = 0;
      rst_left = 2;
      rst = 1'b1;
      id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rw = 0;
      id_mem_read = 0; id_mdu = 0; id_rs = '0; id_rt = '0; id_rd = '0;
      ex_branch_taken = 0;

      for (cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         // Reset: initial, occasional random, and once in the middle of an MDU op.
         if (rst_left == 0) begin
            if (!did_mid_reset && m_age == 2) begin
               rst_left = 1;
               did_mid_reset = 1;
            end else if ($urandom_range(0, 199) == 0) begin
               rst_left = int'($urandom_range(1, 2));
            end
         end
         rst = (rst_left > 0);
         if (rst_left > 0) rst_left--;

         // A stalled ID instruction stays put; otherwise fetch a new one.
         if (!hold) begin
            id_valid    = ($urandom_range(0, 99) < 85);
            id_rs       = REG_W'(pick_reg());
            id_rt       = REG_W'(pick_reg());
            id_rd       = REG_W'(pick_reg());
            id_uses_rs  = ($urandom_range(0, 99) < 75);
            id_uses_rt  = ($urandom_range(0, 99) < 60);
            id_rw       = ($urandom_range(0, 99) < 70);
            id_mem_read = ($urandom_range(0, 99) < 35);
            id_mdu      = ($urandom_range(0, 99) < 15);
         end
         ex_branch_taken = ($urandom_range(0, 99) < 7);

         // Expected controls from the hazard rules.
         ds = 0;
         if (depends(m_pipe[0])) begin
`ifdef HAZARD_FWD_EN
            if (m_pipe[0].ld) ds = 1;
`else
            ds = 1;
`endif
         end
`ifndef HAZARD_FWD_EN
         if (depends(m_pipe[1])) ds = 1;
`endif
         if (rst) begin
            flush = 0; stall = 0; busy = 0;
         end else begin
            flush = ex_branch_taken;
            busy  = (m_age != 0);
            if (flush) stall = 0;
            else if (ds) stall = 1;
            else if (m_age != 0) stall = (m_age + 1 < LAT);
            else stall = id_valid && id_mdu;
         end

         @(negedge clk);
         check("pc_write",     pc_write,     !stall);
         check("if_id_write",  if_id_write,  !stall);
         check("id_ex_bubble", id_ex_bubble, stall);
         check("if_id_flush",  if_id_flush,  flush);
         check("id_ex_flush",  id_ex_flush,  flush);
         check("mdu_busy",     mdu_busy,     busy);

         // Model state after the coming edge.
         if (rst) begin
            for (int i = 0; i < 3; i++) m_pipe[i] = '{0, 0, 0, 0};
            m_age = 0;
         end else begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            if (id_valid && !stall && !flush)
               m_pipe[0] = '{1, id_rw, int'(id_rd), id_mem_read};
            else
               m_pipe[0] = '{0, 0, 0, 0};
            if (flush) m_age = 0;
            else if (m_age != 0) m_age = stall ? m_age + 1 : 0;
            else if (!ds && id_valid && id_mdu) m_age = 1;
         end
         hold = !rst && stall;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core; it decides when forwarding cannot cover a dependency. It sits beside the ID stage, tracks the destination register of every in-flight writer in its own registered scoreboard (EX, MEM, WB), and drives stall, bubble and flush controls into the PC, IF/ID and ID/EX registers. It also holds ID for multi-cycle multiply/divide (MDU) operations and squashes wrong-path instructions on a taken branch.

## Interface
- MDU_LATENCY, 4: total cycles an MDU op occupies ID; legal range 2..16.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  ID source registers
- id_uses_rs, id_uses_rt  in  1 each  the source is actually read
- id_rd  in  5  ID destination register
- id_rw  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- id_mdu  in  1  ID instruction is an MDU op
- ex_branch_taken  in  1  branch resolved taken in EX
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- id_ex_bubble  out  1  ID/EX loads a NOP
- if_id_flush, id_ex_flush  out  1 each  squash IF/ID and ID/EX contents
- mdu_busy  out  1  FSM in MDU_BUSY

## Operation
- Scoreboard: three entries {valid, rw, rd, mem_read}: sb_ex, sb_mem, sb_wb.
- Every edge: sb_wb<=sb_mem, sb_mem<=sb_ex; sb_ex<=ID fields if id_valid and no stall and no flush, else invalid.
- A match means: entry valid, rw=1, rd!=0, rd equals a source that is both used (id_uses_*) and present in ID (id_valid).
- data_stall with HAZARD_FWD_EN: match against sb_ex with mem_read=1 (load-use) only.
- data_stall without HAZARD_FWD_EN: match against sb_ex or sb_mem. sb_wb never stalls, because the register file writes before it reads.
- FSM states:
  - IDLE: if id_valid and id_mdu and no data_stall, assert stall, load cnt<=MDU_LATENCY-2, go to MDU_BUSY.
  - MDU_BUSY: if cnt!=0, stall and decrement. If cnt==0, release the stall (the op advances) and go to IDLE.
- Stall: pc_write=0, if_id_write=0, id_ex_bubble=1. stall = data_stall | MDU stall.
- Flush: if ex_branch_taken, then if_id_flush=1 and id_ex_flush=1, pc_write=1, stall forced to 0, FSM goes to IDLE, and cnt is discarded.
- Priority: flush > data_stall > MDU start. A pending MDU op waits for the load-use stall to clear before the counter starts.

## Timing
- Control outputs are combinational from registered state (scoreboard, FSM, cnt) and same-cycle ID/EX inputs. They take effect at the next edge.
- Load-use: exactly 1 stall cycle with forwarding. Without forwarding: 2 cycles for an EX-stage producer, 1 for a MEM-stage producer.
- MDU op: MDU_LATENCY-1 stall cycles. It advances on the MDU_LATENCY-th cycle in ID.
- Reset: scoreboard invalid, FSM IDLE, cnt=0. While rst is high: pc_write=1, if_id_write=1, id_ex_bubble=0, flushes=0, mdu_busy=0. Reset mid-MDU aborts the op.
- Stall plus flush in the same cycle: flush wins and no bubble is asserted, because the ID instruction is killed.

## Configuration
- HAZARD_FWD_EN defined: the forwarding unit is present, and only load-use hazards stall.
- HAZARD_FWD_EN undefined: no forwarding, and every RAW hazard against EX or MEM stalls until the producer reaches WB.
- The FSM and flush behaviour are identical in both builds.

## Structure
- Shared pipeline package holds:
  - the FSM state enum {IDLE, MDU_BUSY}
  - the scoreboard entry struct
  - REG_ZERO = 5'd0 and the 5-bit register index width
- One sub-module, hazard_scoreboard, holds the 3-entry shift and match logic.
- The FSM, counter and output muxing stay in hazard_unit.

## Test plan
- Load-use, FWD_EN: lw $8 in EX, then add using rs=$8 in ID → 1 cycle of pc_write=0 / id_ex_bubble=1, then the add advances.
- No FWD_EN: add $9 followed directly by sub reading rt=$9 → 2 stall cycles. Destination $0 → no stall.
- MDU with MDU_LATENCY=4: id_mdu=1 → mdu_busy high for 3 cycles and 3 stall cycles, then release with mdu_busy=0.
- Branch during MDU_BUSY: ex_branch_taken=1 at cnt=1 → both flushes high, stall dropped, FSM IDLE the next cycle.
- Load-use and MDU together: lw $4, then an MDU op reading $4 → 1 load stall, then 3 MDU stall cycles (4 total).
- Reset asserted mid-MDU_BUSY → outputs immediately at reset values. After release, no stall against stale scoreboard entries.
